cgol_board_sequencer: RTL

- Drives a registered Game of Life cell evaluator for one generation on a ROWS x COLS toroidal board.
- Snapshots the current board, then streams one 9-bit 3x3 neighbourhood window per clock in row-major order.
- Collects the returned next-state bit for each window after a fixed latency and publishes the assembled next board with a done pulse.
- Sits between board storage/display logic and the per-cell evaluator.

---
 rtl/cgol_pkg.sv | 26 ++
 rtl/cgol_window_mux.sv | 44 ++++
 rtl/cgol_board_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cgol_pkg.sv
// Shared types and constants for the Game of Life board sequencer.
// No logic; imported by the sequencer and its window extractor.
// Window bit positions are fixed; the centre cell sits at bit 5.
package cgol_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int WINDOW_W    = 9;
  localparam int GEN_COUNT_W = 16;

  // Neighbourhood bit positions within a window
  localparam int NW     = 0;
  localparam int NORTH  = 1;
  localparam int NE     = 2;
  localparam int WEST   = 3;
  localparam int EAST   = 4;
  localparam int CENTER = 5;
  localparam int SW     = 6;
  localparam int SOUTH  = 7;
  localparam int SE     = 8;

endpackage

// File: rtl/cgol_window_mux.sv
// Extracts the 3x3 toroidal neighbourhood of (row, col) from a board snapshot.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module cgol_window_mux
  import cgol_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic [ROWS*COLS-1:0]     board,
  input  logic [$clog2(ROWS)-1:0]  row,
  input  logic [$clog2(COLS)-1:0]  col,
  output logic [WINDOW_W-1:0]      window
);

  localparam int IW = $clog2(ROWS*COLS);

  int r, c, rm, rp, cm, cp;

  function automatic logic cell_at(input int rr, input int cc);
    return board[IW'(rr * COLS + cc)];
  endfunction

  // Explicit compare-and-wrap so non-power-of-two boards index correctly
  always_comb begin
    r  = int'(row);
    c  = int'(col);
    rm = (r == 0)        ? ROWS - 1 : r - 1;
    rp = (r == ROWS - 1) ? 0        : r + 1;
    cm = (c == 0)        ? COLS - 1 : c - 1;
    cp = (c == COLS - 1) ? 0        : c + 1;
    window         = '0;
    window[NW]     = cell_at(rm, cm);
    window[NORTH]  = cell_at(rm, c);
    window[NE]     = cell_at(rm, cp);
    window[WEST]   = cell_at(r,  cm);
    window[EAST]   = cell_at(r,  cp);
    window[CENTER] = cell_at(r,  c);
    window[SW]     = cell_at(rp, cm);
    window[SOUTH]  = cell_at(rp, c);
    window[SE]     = cell_at(rp, cp);
  end

endmodule

// File: rtl/cgol_board_sequencer.sv
// Sequences one Game of Life generation: snapshot board, stream windows, collect results.
// Latency: windows at T+1..T+N, o_done/o_next_board at T+N+CELL_LATENCY+1 after start edge T.
// Backpressure: none; evaluator must return each result exactly CELL_LATENCY cycles later.
module cgol_board_sequencer
  import cgol_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int CELL_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [ROWS*COLS-1:0]     i_board,
  output logic                     o_busy,
  output logic [WINDOW_W-1:0]      o_window,
  output logic                     o_win_valid,
  output logic [$clog2(ROWS)-1:0]  o_win_row,
  output logic [$clog2(COLS)-1:0]  o_win_col,
  input  logic                     i_cell,
  output logic [ROWS*COLS-1:0]     o_next_board,
  output logic                     o_done,
  output logic [GEN_COUNT_W-1:0]   o_gen_count
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(N);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_t          state, state_next;
  logic            start_load, scan_step, finish, last_tag;
  logic [N-1:0]    snapshot, acc, acc_next;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [IW-1:0]   idx, win_idx;
  logic [WINDOW_W-1:0] window_c;
  logic            tag_vld [CELL_LATENCY];
  logic [IW-1:0]   tag_idx [CELL_LATENCY];

  cgol_window_mux #(.ROWS(ROWS), .COLS(COLS)) u_window_mux (
    .board  (snapshot),
    .row    (row),
    .col    (col),
    .window (window_c)
  );

  assign last_tag = tag_vld[CELL_LATENCY-1] && (tag_idx[CELL_LATENCY-1] == IDX_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    start_load = 1'b0;
    scan_step  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          start_load = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        scan_step = 1'b1;
        if (idx == IDX_LAST) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_tag) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot, row/col scan counters and registered window outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot    <= '0;
      row         <= '0;
      col         <= '0;
      idx         <= '0;
      win_idx     <= '0;
      o_window    <= '0;
      o_win_valid <= 1'b0;
      o_win_row   <= '0;
      o_win_col   <= '0;
    end else begin
      o_win_valid <= scan_step;
      if (start_load) begin
        snapshot <= i_board;
        row      <= '0;
        col      <= '0;
        idx      <= '0;
      end
      if (scan_step) begin
        o_window  <= window_c;
        o_win_row <= row;
        o_win_col <= col;
        win_idx   <= idx;
        idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Tag pipeline marks which cycles carry a valid evaluator result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CELL_LATENCY; k++) begin
        tag_vld[k] <= 1'b0;
        tag_idx[k] <= '0;
      end
    end else begin
      tag_vld[0] <= o_win_valid;
      tag_idx[0] <= win_idx;
      for (int k = 1; k < CELL_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  // Merge the tagged result; the final bit is folded in on the publish edge
  always_comb begin
    acc_next = acc;
    if (tag_vld[CELL_LATENCY-1]) acc_next[tag_idx[CELL_LATENCY-1]] = i_cell;
  end

  // Accumulator: cleared per generation, updated on tagged cycles only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             acc <= '0;
    else if (start_load) acc <= '0;
    else                 acc <= acc_next;
  end

  // Busy flag, whole-board publish, done pulse and generation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_next_board <= '0;
      o_gen_count  <= '0;
    end else begin
      o_busy <= (state != IDLE) && !finish;
      o_done <= finish;
      if (finish) begin
        o_next_board <= acc_next;
        o_gen_count  <= o_gen_count + GEN_COUNT_W'(1);
      end
    end
  end

endmodule
